lsu_dccm_req_stage: RTL and testbench
=====================================

// Module: lsu_dccm_req_stage
// PURPOSE
//   Load/store request stage directly downstream of the 0xF004_0000/64KB range checker.
//   - Takes core LSU requests with the checker's combinational in_range/in_region verdict
//     for req_addr.
//   - Classifies each accepted request: DCCM hit, external bus, or access/misalign fault.
//   - Queues hits and bus requests in order in a small FIFO that feeds the DCCM and bus ports.
//   - Reports faults on a one-cycle error pulse.
// PARAMETERS
//   DEPTH   2    request FIFO entries (power of two, >=2)
//   IDX_W   14   DCCM word index width (addr[15:2] of the 64KB window)
// PORTS
//   clk           in   1      core clock
//   rst_l         in   1      asynchronous active-low reset
//   req_valid     in   1      LSU request valid
//   req_ready     out  1      stage can accept (FIFO not full)
//   req_addr      in   32     byte address; also drives the range checker
//   req_size      in   2      0=byte 1=half 2=word (3 illegal -> misalign fault)
//   req_write     in   1      1=store 0=load
//   req_wdata     in   32     store data, byte-lane aligned
//   in_range      in   1      range checker: addr[31:16]==16'hF004
//   in_region     in   1      range checker: addr[31:28]==4'hF
//   dccm_valid    out  1      DCCM request valid (FIFO head targets DCCM)
//   dccm_ready    in   1      DCCM accepts
//   dccm_idx      out  IDX_W  word index = head addr[15:2]
//   dccm_wr       out  1      store
//   dccm_be       out  4      byte enables
//   dccm_wdata    out  32     store data
//   bus_valid     out  1      bus request valid (FIFO head targets bus)
//   bus_ready     in   1      bus accepts
//   bus_addr      out  32     full byte address
//   bus_wr/bus_be/bus_wdata  out 1/4/32  as DCCM equivalents
//   err_valid     out  1      one-cycle fault pulse
//   err_type      out  2      1=misaligned 2=region hole (in_region & !in_range)
//   err_addr      out  32     faulting address
// BEHAVIOUR
//   - Reset (async, rst_l low):
//     - FIFO emptied; req_ready=1.
//     - dccm_valid, bus_valid, err_valid = 0; err_type=0; err_addr=0.
//     - Data outputs are don't-care while their valid is 0.
//   - Accept: req_valid & req_ready on a rising clk edge.
//   - Classification on accept, first match wins:
//     1. Misaligned: size==3, size==1 & addr[0], or size==2 & addr[1:0]!=0 -> err_type=1.
//     2. Region hole: in_region & !in_range -> err_type=2.
//     3. DCCM: in_range.
//     4. Bus: otherwise.
//   - Faults do not enter the FIFO:
//     - err_valid=1 in the cycle after accept, for exactly one cycle.
//     - err_addr/err_type registered with it.
//     - Back-to-back faults give back-to-back pulses.
//   - FIFO entry contents: target bit, addr, write, be, wdata.
//   - Byte enables:
//     - byte: 1<<addr[1:0]
//     - half: 3<<addr[1:0]
//     - word: 4'hF
//   - Output ports:
//     - Only the head entry is presented; strict in-order across DCCM and bus.
//     - A bus head blocks a younger DCCM entry and vice versa.
//     - dccm_valid = !empty & head.target==DCCM; bus_valid = !empty & head.target==BUS.
//     - Pop on the valid&ready of the port matching the head.
//     - Head outputs are stable while valid & !ready.
//   - Latency: accept at edge N -> head valid from cycle N+1 if the FIFO was empty.
//     No combinational path from req_* to any output.
//   - req_ready = !full. It is registered/derived from the count, never from dccm_ready or bus_ready.
//   - Full: req_ready=0 even if a pop happens in the same cycle (no bypass).
//   - Empty: both output valids are 0.
//   - Simultaneous push and pop: count unchanged; pointers advance, wrapping modulo DEPTH.
//   - Fault accept while FIFO non-empty: the FIFO is unaffected and the error pulses independently.
//   - Reset mid-operation: in-flight entries are discarded without completion; a pending err pulse is cancelled.
// TESTING
//   1. Load word 0xF004_0010, dccm_ready=1 -> next cycle: dccm_valid=1, idx=14'h0004, be=4'hF, wr=0; bus_valid=0.
//   2. Store byte 0xF004_FFFF, wdata=0xAB000000 -> dccm_be=4'b1000, dccm_wdata=0xAB000000, dccm_idx=14'h3FFF.
//   3. Load 0xF005_0000 (in_region=1, in_range=0) -> err_valid pulse, err_type=2, err_addr=0xF005_0000; FIFO stays empty.
//   4. Half-word at 0xF004_0001 -> err_type=1; word at 0x2000_0002 -> err_type=1 (misaligned wins outside the region).
//   5. Hold dccm_ready=0; push DCCM, bus, DCCM -> req_ready=0 after two pushes.
//      Bus is held behind the DCCM head; releasing ready drains in order DCCM, bus, DCCM.
//   6. Assert rst_l=0 mid-drain with a full FIFO -> all valids 0 immediately; req_ready=1 after reset release.

Source files
------------

// File: rtl/lsu_dccm_req_stage.sv
// Load/store request stage behind the DCCM range checker: classifies requests,
// queues DCCM/bus work in strict order and reports faults as a one-cycle pulse.
module lsu_dccm_req_stage #(
  parameter int DEPTH = 2,
  parameter int IDX_W = 14
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_addr,
  input  logic [1:0]       req_size,
  input  logic             req_write,
  input  logic [31:0]      req_wdata,
  input  logic             in_range,
  input  logic             in_region,
  output logic             dccm_valid,
  input  logic             dccm_ready,
  output logic [IDX_W-1:0] dccm_idx,
  output logic             dccm_wr,
  output logic [3:0]       dccm_be,
  output logic [31:0]      dccm_wdata,
  output logic             bus_valid,
  input  logic             bus_ready,
  output logic [31:0]      bus_addr,
  output logic             bus_wr,
  output logic [3:0]       bus_be,
  output logic [31:0]      bus_wdata,
  output logic             err_valid,
  output logic [1:0]       err_type,
  output logic [31:0]      err_addr
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic T_DCCM = 1'b0;
  localparam logic T_BUS  = 1'b1;

  // Handshake: a transfer happens on a rising edge where valid & ready are both 1.
  // Valid never depends on ready; payload holds steady while valid & !ready.

  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic             r_tgt   [DEPTH];
  logic [31:0]      r_addr  [DEPTH];
  logic             r_wr    [DEPTH];
  logic [3:0]       r_be    [DEPTH];
  logic [31:0]      r_wdata [DEPTH];
  logic             r_err_valid;
  logic [1:0]       r_err_type;
  logic [31:0]      r_err_addr;

  logic             w_full;
  logic             w_empty;
  logic             w_accept;
  logic             w_misalign;
  logic             w_hole;
  logic             w_fault;
  logic             w_push;
  logic             w_pop;
  logic [3:0]       w_be;
  logic             w_head_tgt;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign req_ready = !w_full;
  assign w_accept  = req_valid & req_ready;

  // Misalignment outranks the region hole, so odd addresses outside the window still fault as misaligned.
  assign w_misalign = (req_size == 2'd3) ||
                      ((req_size == 2'd1) && req_addr[0]) ||
                      ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
  assign w_hole     = in_region & !in_range;
  assign w_fault    = w_misalign | w_hole;
  assign w_push     = w_accept & !w_fault;

  always_comb begin
    w_be = 4'hF;
    case (req_size)
      2'd0:    w_be = 4'b0001 << req_addr[1:0];
      2'd1:    w_be = 4'b0011 << req_addr[1:0];
      default: w_be = 4'hF;
    endcase
  end

  assign w_head_tgt = r_tgt[r_rptr];
  assign w_pop      = !w_empty & ((w_head_tgt == T_BUS) ? bus_ready : dccm_ready);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tgt[r_wptr]   <= in_range ? T_DCCM : T_BUS;
      r_addr[r_wptr]  <= req_addr;
      r_wr[r_wptr]    <= req_write;
      r_be[r_wptr]    <= w_be;
      r_wdata[r_wptr] <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_err_valid <= 1'b0;
      r_err_type  <= 2'd0;
      r_err_addr  <= 32'd0;
    end else begin
      r_err_valid <= w_accept & w_fault;
      if (w_accept & w_fault) begin
        r_err_type <= w_misalign ? 2'd1 : 2'd2;
        r_err_addr <= req_addr;
      end
    end
  end

  assign dccm_valid = !w_empty & (w_head_tgt == T_DCCM);
  assign dccm_idx   = r_addr[r_rptr][IDX_W+1:2];
  assign dccm_wr    = r_wr[r_rptr];
  assign dccm_be    = r_be[r_rptr];
  assign dccm_wdata = r_wdata[r_rptr];

  assign bus_valid  = !w_empty & (w_head_tgt == T_BUS);
  assign bus_addr   = r_addr[r_rptr];
  assign bus_wr     = r_wr[r_rptr];
  assign bus_be     = r_be[r_rptr];
  assign bus_wdata  = r_wdata[r_rptr];

  assign err_valid  = r_err_valid;
  assign err_type   = r_err_type;
  assign err_addr   = r_err_addr;

endmodule

// File: tb/tb_lsu_dccm_req_stage.sv
// Directed bench for lsu_dccm_req_stage: a table of single requests plus
// hand-written sequences for back-pressure, ordering, back-to-back faults and reset.
module tb_lsu_dccm_req_stage;

  localparam logic [1:0] K_DCCM = 2'd0;
  localparam logic [1:0] K_BUS  = 2'd1;
  localparam logic [1:0] K_ERR  = 2'd2;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        wr;
    logic [31:0] wdata;
    logic [1:0]  kind;
    logic [1:0]  etype;
    logic [3:0]  be;
    logic [13:0] idx;
  } vec_t;

  logic        clk;
  logic        rst_l;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_write;
  logic [31:0] req_wdata;
  logic        in_range;
  logic        in_region;
  logic        dccm_valid;
  logic        dccm_ready;
  logic [13:0] dccm_idx;
  logic        dccm_wr;
  logic [3:0]  dccm_be;
  logic [31:0] dccm_wdata;
  logic        bus_valid;
  logic        bus_ready;
  logic [31:0] bus_addr;
  logic        bus_wr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        err_valid;
  logic [1:0]  err_type;
  logic [31:0] err_addr;

  int n_cmp;
  int n_bad;
  vec_t tbl[14];

  lsu_dccm_req_stage #(.DEPTH(2), .IDX_W(14)) dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_write  (req_write),
    .req_wdata  (req_wdata),
    .in_range   (in_range),
    .in_region  (in_region),
    .dccm_valid (dccm_valid),
    .dccm_ready (dccm_ready),
    .dccm_idx   (dccm_idx),
    .dccm_wr    (dccm_wr),
    .dccm_be    (dccm_be),
    .dccm_wdata (dccm_wdata),
    .bus_valid  (bus_valid),
    .bus_ready  (bus_ready),
    .bus_addr   (bus_addr),
    .bus_wr     (bus_wr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .err_valid  (err_valid),
    .err_type   (err_type),
    .err_addr   (err_addr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // range checker model feeds in_range/in_region from the address
  task automatic drive_req(input logic [31:0] a, input logic [1:0] s, input logic w,
                           input logic [31:0] d);
    req_valid = 1'b1;
    req_addr  = a;
    req_size  = s;
    req_write = w;
    req_wdata = d;
    in_range  = (a[31:16] == 16'hF004);
    in_region = (a[31:28] == 4'hF);
  endtask

  task automatic drop_req();
    req_valid = 1'b0;
  endtask

  task automatic chk_valids(input string nm, input logic [2:0] exp);
    chk(nm, {29'd0, dccm_valid, bus_valid, err_valid}, {29'd0, exp});
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    rst_l      = 1'b0;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_size   = '0;
    req_write  = 1'b0;
    req_wdata  = '0;
    in_range   = 1'b0;
    in_region  = 1'b0;
    dccm_ready = 1'b1;
    bus_ready  = 1'b1;

    //             addr          sz   wr    wdata         kind    et    be     idx
    tbl[0]  = '{32'hF004_0010, 2'd2, 1'b0, 32'h0000_0000, K_DCCM, 2'd0, 4'hF, 14'h0004};
    tbl[1]  = '{32'hF004_FFFF, 2'd0, 1'b1, 32'hAB00_0000, K_DCCM, 2'd0, 4'h8, 14'h3FFF};
    tbl[2]  = '{32'hF005_0000, 2'd2, 1'b0, 32'h0000_0000, K_ERR,  2'd2, 4'h0, 14'h0000};
    tbl[3]  = '{32'hF004_0001, 2'd1, 1'b0, 32'h0000_0000, K_ERR,  2'd1, 4'h0, 14'h0000};
    tbl[4]  = '{32'h2000_0002, 2'd2, 1'b0, 32'h0000_0000, K_ERR,  2'd1, 4'h0, 14'h0000};
    tbl[5]  = '{32'h2000_0006, 2'd1, 1'b1, 32'h1234_0000, K_BUS,  2'd0, 4'hC, 14'h0000};
    tbl[6]  = '{32'h1000_0003, 2'd0, 1'b0, 32'h0000_0000, K_BUS,  2'd0, 4'h8, 14'h0000};
    tbl[7]  = '{32'hF004_0002, 2'd3, 1'b0, 32'h0000_0000, K_ERR,  2'd1, 4'h0, 14'h0000};
    tbl[8]  = '{32'hF004_1236, 2'd1, 1'b0, 32'h0000_0000, K_DCCM, 2'd0, 4'hC, 14'h048D};
    tbl[9]  = '{32'hF100_0000, 2'd2, 1'b0, 32'h0000_0000, K_ERR,  2'd2, 4'h0, 14'h0000};
    tbl[10] = '{32'hF004_0005, 2'd0, 1'b1, 32'h0000_5600, K_DCCM, 2'd0, 4'h2, 14'h0001};
    tbl[11] = '{32'h0000_0000, 2'd2, 1'b1, 32'hDEAD_BEEF, K_BUS,  2'd0, 4'hF, 14'h0000};
    tbl[12] = '{32'hF100_0001, 2'd1, 1'b0, 32'h0000_0000, K_ERR,  2'd1, 4'h0, 14'h0000};
    tbl[13] = '{32'hF004_0008, 2'd1, 1'b1, 32'h0000_BEEF, K_DCCM, 2'd0, 4'h3, 14'h0002};

    // reset state
    repeat (2) @(negedge clk);
    chk("reset_ready", {31'd0, req_ready}, 32'd1);
    chk_valids("reset_valids", 3'b000);
    chk("reset_err_type", {30'd0, err_type}, 32'd0);
    chk("reset_err_addr", err_addr, 32'd0);
    rst_l = 1'b1;

    // table: one request per slot, both ports ready
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive_req(tbl[i].addr, tbl[i].size, tbl[i].wr, tbl[i].wdata);
      @(negedge clk);
      drop_req();
      case (tbl[i].kind)
        K_DCCM: begin
          chk_valids($sformatf("v%0d_valids", i), 3'b100);
          chk($sformatf("v%0d_idx", i), {18'd0, dccm_idx}, {18'd0, tbl[i].idx});
          chk($sformatf("v%0d_be", i), {28'd0, dccm_be}, {28'd0, tbl[i].be});
          chk($sformatf("v%0d_wr", i), {31'd0, dccm_wr}, {31'd0, tbl[i].wr});
          chk($sformatf("v%0d_wdata", i), dccm_wdata, tbl[i].wdata);
        end
        K_BUS: begin
          chk_valids($sformatf("v%0d_valids", i), 3'b010);
          chk($sformatf("v%0d_addr", i), bus_addr, tbl[i].addr);
          chk($sformatf("v%0d_be", i), {28'd0, bus_be}, {28'd0, tbl[i].be});
          chk($sformatf("v%0d_wr", i), {31'd0, bus_wr}, {31'd0, tbl[i].wr});
          chk($sformatf("v%0d_wdata", i), bus_wdata, tbl[i].wdata);
        end
        default: begin
          chk_valids($sformatf("v%0d_valids", i), 3'b001);
          chk($sformatf("v%0d_etype", i), {30'd0, err_type}, {30'd0, tbl[i].etype});
          chk($sformatf("v%0d_eaddr", i), err_addr, tbl[i].addr);
        end
      endcase
      @(negedge clk);
      chk_valids($sformatf("v%0d_after", i), 3'b000);
      chk($sformatf("v%0d_ready", i), {31'd0, req_ready}, 32'd1);
    end

    // back-to-back faults give back-to-back pulses
    @(negedge clk);
    drive_req(32'hF005_0000, 2'd2, 1'b0, 32'd0);
    @(negedge clk);
    drive_req(32'hF004_0003, 2'd1, 1'b0, 32'd0);
    chk_valids("b2b_first_valids", 3'b001);
    chk("b2b_first_addr", err_addr, 32'hF005_0000);
    chk("b2b_first_type", {30'd0, err_type}, 32'd2);
    @(negedge clk);
    drop_req();
    chk_valids("b2b_second_valids", 3'b001);
    chk("b2b_second_addr", err_addr, 32'hF004_0003);
    chk("b2b_second_type", {30'd0, err_type}, 32'd1);
    @(negedge clk);
    chk_valids("b2b_end", 3'b000);

    // ordering: DCCM, bus, DCCM with DCCM stalled
    dccm_ready = 1'b0;
    drive_req(32'hF004_0100, 2'd2, 1'b0, 32'd0);
    @(negedge clk);
    drive_req(32'h3000_0000, 2'd2, 1'b1, 32'h5555_AAAA);
    chk("ord_ready_one", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    drive_req(32'hF004_0200, 2'd2, 1'b0, 32'd0);
    chk("ord_ready_full", {31'd0, req_ready}, 32'd0);
    chk_valids("ord_head_dccm", 3'b100);
    chk("ord_head_idx", {18'd0, dccm_idx}, 32'h0000_0040);
    repeat (2) @(negedge clk);
    chk("ord_hold_ready", {31'd0, req_ready}, 32'd0);
    chk_valids("ord_hold_valids", 3'b100);
    chk("ord_hold_idx", {18'd0, dccm_idx}, 32'h0000_0040);
    dccm_ready = 1'b1;
    @(negedge clk);
    chk_valids("ord_second_bus", 3'b010);
    chk("ord_second_addr", bus_addr, 32'h3000_0000);
    chk("ord_second_wdata", bus_wdata, 32'h5555_AAAA);
    chk("ord_second_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    drop_req();
    chk_valids("ord_third_dccm", 3'b100);
    chk("ord_third_idx", {18'd0, dccm_idx}, 32'h0000_0080);
    @(negedge clk);
    chk_valids("ord_drained", 3'b000);

    // reset with a full FIFO
    dccm_ready = 1'b0;
    drive_req(32'hF004_0020, 2'd2, 1'b0, 32'd0);
    @(negedge clk);
    drive_req(32'hF004_0024, 2'd2, 1'b0, 32'd0);
    @(negedge clk);
    drop_req();
    chk("rst_pre_full", {31'd0, req_ready}, 32'd0);
    rst_l = 1'b0;
    #1;
    chk_valids("rst_mid_valids", 3'b000);
    @(negedge clk);
    rst_l = 1'b1;
    dccm_ready = 1'b1;
    @(negedge clk);
    chk("rst_post_ready", {31'd0, req_ready}, 32'd1);
    chk_valids("rst_post_valids", 3'b000);

    // reset cancels a pending error pulse
    drive_req(32'hF005_0010, 2'd2, 1'b0, 32'd0);
    @(posedge clk);
    #1;
    drop_req();
    chk_valids("rst_err_pending", 3'b001);
    rst_l = 1'b0;
    #1;
    chk_valids("rst_err_cancel", 3'b000);
    @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);
    chk_valids("rst_err_after", 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
